// File: rtl/alu_sequencer.sv
// Multi-cycle shift/multiply sequencer in front of a single-step ALU; passes core operands through when idle.
// Optional abort input is enabled by defining ALU_SEQ_ABORT_EN.
module alu_sequencer #(
  parameter int BITS = 16,
  parameter int CNTW = 4
) (
  input  logic            CLK,
  input  logic            RSTb,
  input  logic [BITS-1:0] core_a,
  input  logic [BITS-1:0] core_b,
  input  logic [4:0]      core_op,
  input  logic            start,
  input  logic [1:0]      cmd,
  input  logic [BITS-1:0] op_a,
  input  logic [BITS-1:0] op_b,
`ifdef ALU_SEQ_ABORT_EN
  input  logic            abort,
`endif
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] result,
  output logic [BITS-1:0] alu_a,
  output logic [BITS-1:0] alu_b,
  output logic [4:0]      alu_op,
  input  logic [BITS-1:0] alu_out
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_MUL_ADD = 3'd2,
    S_MUL_SHL = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [1:0] CMD_SHL = 2'd0;
  localparam logic [1:0] CMD_SHR = 2'd1;
  localparam logic [1:0] CMD_SAR = 2'd2;
  localparam logic [1:0] CMD_MUL = 2'd3;

  localparam logic [4:0] OP_MOVE = 5'd0;
  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_SAR  = 5'd16;
  localparam logic [4:0] OP_SHR  = 5'd17;
  localparam logic [4:0] OP_SHL  = 5'd18;

  state_t          r_state;
  logic [1:0]      r_cmd;
  logic [BITS-1:0] r_work;
  logic [BITS-1:0] r_mcand;
  logic [BITS-1:0] r_mplier;
  logic [BITS-1:0] r_acc;
  logic [BITS-1:0] r_result;
  logic [CNTW-1:0] r_cnt;
  logic [CNTW-1:0] r_iter;
  logic            r_done;

  logic            w_abort;
  logic            w_abort_hit;
  logic [BITS-1:0] w_mplier_next;
  logic [BITS-1:0] w_alu_a;
  logic [BITS-1:0] w_alu_b;
  logic [4:0]      w_alu_op;

`ifdef ALU_SEQ_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Abort only bites while a step is executing; IDLE and DONE are unaffected.
  assign w_abort_hit   = w_abort && (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_mplier_next = r_mplier >> 1;

  function automatic logic [4:0] shift_op(input logic [1:0] c);
    case (c)
      CMD_SHR: shift_op = OP_SHR;
      CMD_SAR: shift_op = OP_SAR;
      default: shift_op = OP_SHL;
    endcase
  endfunction

  // ALU operand mux: core passthrough unless the sequencer is stepping.
  always_comb begin
    w_alu_a  = core_a;
    w_alu_b  = core_b;
    w_alu_op = core_op;
    case (r_state)
      S_SHIFT: begin
        w_alu_a  = {BITS{1'b0}};
        w_alu_b  = r_work;
        w_alu_op = shift_op(r_cmd);
      end
      S_MUL_ADD: begin
        if (r_mplier[0]) begin
          w_alu_a  = r_acc;
          w_alu_b  = r_mcand;
          w_alu_op = OP_ADD;
        end else begin
          w_alu_a  = {BITS{1'b0}};
          w_alu_b  = r_acc;
          w_alu_op = OP_MOVE;
        end
      end
      S_MUL_SHL: begin
        w_alu_a  = {BITS{1'b0}};
        w_alu_b  = r_mcand;
        w_alu_op = OP_SHL;
      end
      default: begin
        w_alu_a  = core_a;
        w_alu_b  = core_b;
        w_alu_op = core_op;
      end
    endcase
  end

  // Sequencer FSM; every step captures alu_out on the same edge it is issued.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      r_state  <= S_IDLE;
      r_cmd    <= 2'd0;
      r_work   <= {BITS{1'b0}};
      r_mcand  <= {BITS{1'b0}};
      r_mplier <= {BITS{1'b0}};
      r_acc    <= {BITS{1'b0}};
      r_result <= {BITS{1'b0}};
      r_cnt    <= {CNTW{1'b0}};
      r_iter   <= {CNTW{1'b0}};
      r_done   <= 1'b0;
    end else if (w_abort_hit) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_cmd    <= cmd;
            r_work   <= op_a;
            r_mcand  <= op_a;
            r_mplier <= op_b;
            r_acc    <= {BITS{1'b0}};
            r_cnt    <= op_b[CNTW-1:0];
            r_iter   <= CNTW'(BITS - 1);
            if (cmd == CMD_MUL) begin
              if (op_b == {BITS{1'b0}}) begin
                r_result <= {BITS{1'b0}};
                r_done   <= 1'b1;
                r_state  <= S_DONE;
              end else begin
                r_state <= S_MUL_ADD;
              end
            end else if (op_b[CNTW-1:0] == {CNTW{1'b0}}) begin
              r_result <= op_a;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_SHIFT;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_work <= alu_out;
          r_cnt  <= r_cnt - CNTW'(1);
          if (r_cnt == CNTW'(1)) begin
            r_result <= alu_out;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_state <= S_SHIFT;
          end
        end
        S_MUL_ADD: begin
          r_acc   <= alu_out;
          r_state <= S_MUL_SHL;
        end
        S_MUL_SHL: begin
          r_mcand  <= alu_out;
          r_mplier <= w_mplier_next;
          r_iter   <= r_iter - CNTW'(1);
          if ((w_mplier_next == {BITS{1'b0}}) || (r_iter == {CNTW{1'b0}})) begin
            r_result <= r_acc;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_state <= S_MUL_ADD;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;
  assign result = r_result;
  assign alu_a  = w_alu_a;
  assign alu_b  = w_alu_b;
  assign alu_op = w_alu_op;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed table-driven bench for alu_sequencer with a behavioural single-step ALU model.
// Abort sequence is compiled only when ALU_SEQ_ABORT_EN is defined.
module tb_alu_sequencer;
  localparam int BITS = 16;

  logic            CLK = 1'b0;
  logic            RSTb;
  logic [BITS-1:0] core_a, core_b, op_a, op_b, result, alu_a, alu_b, alu_out;
  logic [4:0]      core_op, alu_op;
  logic            start, busy, done;
  logic [1:0]      cmd;
`ifdef ALU_SEQ_ABORT_EN
  logic            abort;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 CLK = ~CLK;

  alu_sequencer #(.BITS(16), .CNTW(4)) dut (
    .CLK(CLK), .RSTb(RSTb), .core_a(core_a), .core_b(core_b), .core_op(core_op),
    .start(start), .cmd(cmd), .op_a(op_a), .op_b(op_b),
`ifdef ALU_SEQ_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .result(result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out)
  );

  // Single-step ALU model
  always_comb begin
    case (alu_op)
      5'd0:    alu_out = alu_b;
      5'd1:    alu_out = alu_a + alu_b;
      5'd16:   alu_out = {alu_b[15], alu_b[15:1]};
      5'd17:   alu_out = {1'b0, alu_b[15:1]};
      5'd18:   alu_out = {alu_b[14:0], 1'b0};
      default: alu_out = alu_a ^ alu_b;
    endcase
  end

  typedef struct {
    logic [1:0]  c;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic run_cmd(input logic [1:0] c, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] res, output int lat, output int n18);
    @(negedge CLK);
    start = 1'b1; cmd = c; op_a = a; op_b = b;
    @(posedge CLK); #1;
    start = 1'b0;
    lat = 1; n18 = 0;
    while (!done && lat < 100) begin
      if (busy && alu_op == 5'd18) n18++;
      @(posedge CLK); #1;
      lat++;
    end
    if (!done) lat = -1;
    res = result;
  endtask

  logic [15:0] r;
  int lat, n18, seen_done;

  initial begin
    vecs[0]  = '{2'd0, 16'h0001, 16'h0004, 16'h0010, 5};
    vecs[1]  = '{2'd2, 16'h8000, 16'h000F, 16'hFFFF, 16};
    vecs[2]  = '{2'd1, 16'h8000, 16'h000F, 16'h0001, 16};
    vecs[3]  = '{2'd0, 16'hABCD, 16'h0000, 16'hABCD, 1};
    vecs[4]  = '{2'd1, 16'hF0F0, 16'h0004, 16'h0F0F, 5};
    vecs[5]  = '{2'd2, 16'h7F00, 16'h0003, 16'h0FE0, 4};
    vecs[6]  = '{2'd2, 16'h8001, 16'h0001, 16'hC000, 2};
    vecs[7]  = '{2'd0, 16'h0001, 16'h0013, 16'h0008, 4};
    vecs[8]  = '{2'd3, 16'h0003, 16'h0005, 16'h000F, 7};
    vecs[9]  = '{2'd3, 16'h1234, 16'h0000, 16'h0000, 1};
    vecs[10] = '{2'd3, 16'hFFFF, 16'hFFFF, 16'h0001, 33};
    vecs[11] = '{2'd3, 16'h0100, 16'h0100, 16'h0000, 19};
    vecs[12] = '{2'd3, 16'h0007, 16'h0006, 16'h002A, 7};

    RSTb = 1'b0; start = 1'b0; cmd = 2'd0; op_a = 16'h0; op_b = 16'h0;
    core_op = 5'd5; core_a = 16'h00F0; core_b = 16'h0FF0;
`ifdef ALU_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", {16'd0, result}, 32'h0);
    chk("reset_alu_op", {27'd0, alu_op}, 32'd5);
    chk("reset_alu_a", {16'd0, alu_a}, 32'h00F0);
    chk("reset_alu_b", {16'd0, alu_b}, 32'h0FF0);
    @(negedge CLK); RSTb = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run_cmd(vecs[i].c, vecs[i].a, vecs[i].b, r, lat, n18);
      chk($sformatf("vec%0d_result", i), {16'd0, r}, {16'd0, vecs[i].res});
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      @(posedge CLK); #1;
      chk($sformatf("vec%0d_idle", i), {30'd0, busy, done}, 32'd0);
    end

    // SHL by 4: four sequencer-issued shift steps
    run_cmd(2'd0, 16'h0001, 16'h0004, r, lat, n18);
    chk("shl4_alu_op18_cycles", n18, 4);
    @(posedge CLK); #1;
    chk("passthrough_alu_a", {16'd0, alu_a}, 32'h00F0);

    // start while busy is ignored
    @(negedge CLK); start = 1'b1; cmd = 2'd0; op_a = 16'h0001; op_b = 16'h0008;
    @(posedge CLK); #1; start = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK); start = 1'b1; cmd = 2'd3; op_a = 16'h0003; op_b = 16'h0005;
    @(posedge CLK); #1; start = 1'b0;
    lat = 3;
    while (!done && lat < 100) begin @(posedge CLK); #1; lat++; end
    chk("busy_start_latency", lat, 9);
    chk("busy_start_result", {16'd0, result}, 32'h0100);
    @(posedge CLK); #1;
    chk("busy_start_idle", {31'd0, busy}, 32'd0);

`ifdef ALU_SEQ_ABORT_EN
    @(negedge CLK); start = 1'b1; cmd = 2'd0; op_a = 16'h0003; op_b = 16'h0008;
    @(posedge CLK); #1; start = 1'b0;
    @(posedge CLK); #1;
    abort = 1'b1;
    @(posedge CLK); #1;
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    seen_done = 0;
    repeat (10) begin if (done) seen_done = 1; @(posedge CLK); #1; end
    chk("abort_no_done", seen_done, 0);
    chk("abort_result_kept", {16'd0, result}, 32'h0100);
`endif

    // reset mid-multiply
    @(negedge CLK); start = 1'b1; cmd = 2'd3; op_a = 16'hFFFF; op_b = 16'hFFFF;
    @(posedge CLK); #1; start = 1'b0;
    repeat (5) @(posedge CLK);
    @(negedge CLK); RSTb = 1'b0;
    @(posedge CLK); #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_result", {16'd0, result}, 32'h0);
    @(negedge CLK); RSTb = 1'b1;
    seen_done = 0;
    repeat (40) begin @(posedge CLK); #1; if (done || busy) seen_done = 1; end
    chk("rst_mid_no_done", seen_done, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
